// File: rtl/alu_pkg.sv
// ALU operation encoding shared by decode, the operand stage and the execute ALU.
package alu_pkg;
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alucontrol_t;
endpackage

// File: rtl/exec_operand_stage_if.sv
// Decode-side, forwarding and execute-side signals of the ID/EX operand stage.
// slave = the stage itself, master = its surroundings (decode, MEM/WB, ALU).
interface exec_operand_stage_if #(parameter int XLEN = 32);
   import alu_pkg::*;

   logic            flush;
   logic            id_valid;
   logic            id_ready;
   logic [XLEN-1:0] id_pc;
   logic [XLEN-1:0] id_imm;
   logic [XLEN-1:0] id_rs1_data;
   logic [XLEN-1:0] id_rs2_data;
   logic [4:0]      id_rs1_addr;
   logic [4:0]      id_rs2_addr;
   logic [4:0]      id_rd_addr;
   logic            id_use_rs1;
   logic            id_use_rs2;
   logic            id_sel_pc_a;
   logic            id_sel_imm_b;
   alucontrol_t     id_alucontrol;

   logic            mem_fwd_valid;
   logic [4:0]      mem_fwd_rd;
   logic [XLEN-1:0] mem_fwd_data;
   logic            mem_fwd_busy;
   logic            wb_fwd_valid;
   logic [4:0]      wb_fwd_rd;
   logic [XLEN-1:0] wb_fwd_data;

   logic            ex_valid;
   logic            ex_ready;
   logic [XLEN-1:0] ex_in_a;
   logic [XLEN-1:0] ex_in_b;
   alucontrol_t     ex_alucontrol;
   logic [XLEN-1:0] ex_rs2_val;
   logic [4:0]      ex_rd_addr;
   logic [XLEN-1:0] ex_pc;

   modport slave (
      input  flush, id_valid, id_pc, id_imm, id_rs1_data, id_rs2_data,
             id_rs1_addr, id_rs2_addr, id_rd_addr, id_use_rs1, id_use_rs2,
             id_sel_pc_a, id_sel_imm_b, id_alucontrol,
             mem_fwd_valid, mem_fwd_rd, mem_fwd_data, mem_fwd_busy,
             wb_fwd_valid, wb_fwd_rd, wb_fwd_data, ex_ready,
      output id_ready, ex_valid, ex_in_a, ex_in_b, ex_alucontrol,
             ex_rs2_val, ex_rd_addr, ex_pc
   );

   modport master (
      output flush, id_valid, id_pc, id_imm, id_rs1_data, id_rs2_data,
             id_rs1_addr, id_rs2_addr, id_rd_addr, id_use_rs1, id_use_rs2,
             id_sel_pc_a, id_sel_imm_b, id_alucontrol,
             mem_fwd_valid, mem_fwd_rd, mem_fwd_data, mem_fwd_busy,
             wb_fwd_valid, wb_fwd_rd, wb_fwd_data, ex_ready,
      input  id_ready, ex_valid, ex_in_a, ex_in_b, ex_alucontrol,
             ex_rs2_val, ex_rd_addr, ex_pc
   );
endinterface

// File: rtl/exec_operand_stage.sv
// ID/EX register feeding the ALU: 1-cycle latency, holds under ex_ready=0, stalls on load-use.
// Define EXEC_OPSTAGE_FWD_EN for MEM/WB forwarding; otherwise any MEM/WB match stalls until snooped.
module exec_operand_stage
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input logic                clk,
   input logic                reset,
   exec_operand_stage_if.slave bus
);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1_addr;
      logic [4:0]      rs2_addr;
      logic [4:0]      rd_addr;
      logic            use_rs1;
      logic            use_rs2;
      logic            sel_pc_a;
      logic            sel_imm_b;
      alucontrol_t     alucontrol;
   } instr_t;

   instr_t          ins_q;
   logic            held;
   logic [XLEN-1:0] rs1_q;
   logic [XLEN-1:0] rs2_q;

   logic            mem_hit1, mem_hit2, wb_hit1, wb_hit2;
   logic            hazard, ex_fire, capture;
   logic [XLEN-1:0] fwd1, fwd2;

   // x0 never matches a producer, so it is never forwarded, snooped or stalled on.
   assign mem_hit1 = bus.mem_fwd_valid && (bus.mem_fwd_rd == ins_q.rs1_addr) && (ins_q.rs1_addr != 5'd0);
   assign mem_hit2 = bus.mem_fwd_valid && (bus.mem_fwd_rd == ins_q.rs2_addr) && (ins_q.rs2_addr != 5'd0);
   assign wb_hit1  = bus.wb_fwd_valid  && (bus.wb_fwd_rd  == ins_q.rs1_addr) && (ins_q.rs1_addr != 5'd0);
   assign wb_hit2  = bus.wb_fwd_valid  && (bus.wb_fwd_rd  == ins_q.rs2_addr) && (ins_q.rs2_addr != 5'd0);

`ifdef EXEC_OPSTAGE_FWD_EN
   assign fwd1 = (ins_q.rs1_addr == 5'd0)         ? '0 :
                 (mem_hit1 && !bus.mem_fwd_busy)  ? bus.mem_fwd_data :
                 wb_hit1                          ? bus.wb_fwd_data : rs1_q;
   assign fwd2 = (ins_q.rs2_addr == 5'd0)         ? '0 :
                 (mem_hit2 && !bus.mem_fwd_busy)  ? bus.mem_fwd_data :
                 wb_hit2                          ? bus.wb_fwd_data : rs2_q;
   assign hazard = bus.mem_fwd_busy && ((ins_q.use_rs1 && mem_hit1) || (ins_q.use_rs2 && mem_hit2));
`else
   logic unused_fwd;
   assign unused_fwd = ^{bus.mem_fwd_busy, bus.mem_fwd_data};
   assign fwd1 = (ins_q.rs1_addr == 5'd0) ? '0 : rs1_q;
   assign fwd2 = (ins_q.rs2_addr == 5'd0) ? '0 : rs2_q;
   // Without a bypass, wait until the producer has left WB and been snooped.
   assign hazard = (ins_q.use_rs1 && (mem_hit1 || wb_hit1)) ||
                   (ins_q.use_rs2 && (mem_hit2 || wb_hit2));
`endif

   assign bus.ex_valid      = held && !hazard;
   assign ex_fire           = bus.ex_valid && bus.ex_ready;
   assign bus.id_ready      = !bus.flush && (!held || ex_fire);
   assign capture           = bus.id_valid && bus.id_ready;

   assign bus.ex_in_a       = ins_q.sel_pc_a  ? ins_q.pc  : fwd1;
   assign bus.ex_in_b       = ins_q.sel_imm_b ? ins_q.imm : fwd2;
   assign bus.ex_rs2_val    = fwd2;
   assign bus.ex_alucontrol = ins_q.alucontrol;
   assign bus.ex_rd_addr    = ins_q.rd_addr;
   assign bus.ex_pc         = ins_q.pc;

   always_ff @(posedge clk) begin
      if (reset) begin
         held  <= 1'b0;
         ins_q <= '0;
         rs1_q <= '0;
         rs2_q <= '0;
      end else if (bus.flush) begin
         held <= 1'b0;
      end else if (capture) begin
         held  <= 1'b1;
         ins_q <= '{pc:        bus.id_pc,
                    imm:       bus.id_imm,
                    rs1_addr:  bus.id_rs1_addr,
                    rs2_addr:  bus.id_rs2_addr,
                    rd_addr:   bus.id_rd_addr,
                    use_rs1:   bus.id_use_rs1,
                    use_rs2:   bus.id_use_rs2,
                    sel_pc_a:  bus.id_sel_pc_a,
                    sel_imm_b: bus.id_sel_imm_b,
                    alucontrol: bus.id_alucontrol};
         rs1_q <= bus.id_rs1_data;
         rs2_q <= bus.id_rs2_data;
      end else begin
         if (ex_fire) begin
            held <= 1'b0;
         end
         // Snoop keeps a held operand current once its producer retires from WB.
         if (held && wb_hit1) begin
            rs1_q <= bus.wb_fwd_data;
         end
         if (held && wb_hit2) begin
            rs2_q <= bus.wb_fwd_data;
         end
      end
   end

endmodule

// File: doc/exec_operand_stage.md
# exec_operand_stage

ID/EX pipeline register that sits directly upstream of the execute ALU and drives its `in_a`, `in_b` and `alucontrol`. It captures decoded instructions with a valid/ready handshake and holds them under downstream stall. It resolves RAW hazards by forwarding from MEM/WB, snoops WB writes into held operands, and stalls on load-use.

## Interface
- `XLEN`, 32: operand/PC width.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: kill held instruction (branch redirect/trap).
- `id_valid` in 1 / `id_ready` out 1: decode handshake.
- `id_pc`, `id_imm`, `id_rs1_data`, `id_rs2_data` in XLEN: decoded fields, register-file reads.
- `id_rs1_addr`, `id_rs2_addr`, `id_rd_addr` in 5: register indices.
- `id_use_rs1`, `id_use_rs2` in 1: source actually read.
- `id_sel_pc_a` in 1: operand A = PC instead of rs1.
- `id_sel_imm_b` in 1: operand B = imm instead of rs2.
- `id_alucontrol` in alucontrol_t: ALU operation.
- `mem_fwd_valid` in 1, `mem_fwd_rd` in 5, `mem_fwd_data` in XLEN, `mem_fwd_busy` in 1: EX/MEM producer; busy = load, data not yet available.
- `wb_fwd_valid` in 1, `wb_fwd_rd` in 5, `wb_fwd_data` in XLEN: writeback producer, same cycle as regfile write.
- `ex_valid` out 1 / `ex_ready` in 1: execute handshake.
- `ex_in_a`, `ex_in_b` out XLEN: ALU operands.
- `ex_alucontrol` out alucontrol_t.
- `ex_rs2_val` out XLEN: forwarded rs2, store data.
- `ex_rd_addr` out 5, `ex_pc` out XLEN.

## Operation
- Internal state: `held` (valid bit) and registered copies of all `id_*` fields; `rs1_q`/`rs2_q` hold operand values.
- `ex_fire = ex_valid & ex_ready`; `id_ready = !flush & (!held | ex_fire)`.
- On `id_valid & id_ready`, capture all fields and set `held`. On `ex_fire` with no capture, clear `held`.
- Forwarded source value, per source: if addr==0, the result is 0. Otherwise the priority is: MEM match (`mem_fwd_valid`, rd equal, !busy), then WB match, then the stored `rsN_q`.
- Snoop: every cycle `held` is set and not being replaced, a WB match overwrites `rsN_q` with `wb_fwd_data`. A held instruction therefore stays correct after its producer retires.
- `ex_in_a` = `ex_pc` if `sel_pc_a`, else forwarded rs1. `ex_in_b` = imm if `sel_imm_b`, else forwarded rs2. `ex_rs2_val` = forwarded rs2 always.
- Hazard: a used source, rd≠0, matches MEM with `mem_fwd_busy`=1. The hazard forces `ex_valid`=0; `ex_valid = held & !hazard`.
- `flush`: `held` is 0 next cycle; no capture occurs that cycle.
- x0 is never forwarded, snooped, or hazarded.

## Timing
- Reset: `held`=0, all captured fields 0, `ex_alucontrol`=ALU_ADD. Outputs after reset: `ex_valid`=0, all data outputs 0, `id_ready`=1 (unless `flush`).
- Latency: fire in decode at cycle N → `ex_valid` at N+1, absent hazard. Sustained throughput is 1/cycle with `ex_ready` high.
- Outputs under stall (`ex_valid & !ex_ready`): `ex_alucontrol`, `ex_rd_addr`, `ex_pc` stay stable. Operand values change only via forwarding/snoop.
- Simultaneous `ex_fire` and capture: the new instruction replaces the old one in the same edge, with no bubble.
- `reset` overrides `flush`; `flush` overrides capture and snoop.
- `reset` asserted mid-stall discards the held instruction.

## Configuration
- `EXEC_OPSTAGE_FWD_EN` defined: full MEM/WB forwarding as above.
- Undefined: the output path never forwards, and operands come from `rsN_q` only. The hazard covers any used-source match on valid MEM or valid WB, regardless of busy. The WB snoop into `rsN_q` is retained, so the instruction issues the cycle after its producer leaves WB.

## Test plan
- Reset, then issue `addi` (rs1=x1=5, imm=3, ALU_ADD) → next cycle `ex_valid`=1, `ex_in_a`=5, `ex_in_b`=3.
- Held instruction rs1=x2, MEM rd=x2 data 0x10, WB rd=x2 data 0x20 → `ex_in_a`=0x10 (MEM wins). With `FWD_EN` off → `ex_valid`=0.
- Load-use: MEM rd=x3 busy=1, instruction uses x3 → `ex_valid`=0. Busy drops, data 0x7 → `ex_valid`=1, `ex_in_b`=0x7.
- Stall `ex_ready`=0 for 3 cycles while WB writes x4=0xAB. Then release with WB idle → `ex_rs2_val`=0xAB.
- `flush` with held valid and `id_valid`=1 → next cycle `ex_valid`=0 and nothing captured. Source x0 with MEM rd=x0 data 0xFF → operand 0.
